bus_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer for the shared 9-bit snooping bus {op[8:7],tag[6:4],data[3:0]}.

---
 rtl/bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter/sequencer for the shared 9-bit snooping bus
// {op[8:7], tag[6:4], data[3:0]}. It grants one cache controller at a time, drives
// its message to memory and snoopers, holds the bus for read misses until memory
// returns data, and then pulses done (plus rdValid/err) back to the requester.
// The optional statistics counters are enabled by defining BUS_STATS_EN.
//
// Handshake: req[i] is a level request that the controller holds until done[i].
// The arbiter samples req only in IDLE. From then on it works from the message it
// latched, so later changes to req or reqMsg have no effect on that transaction.
// done[i] is a single-cycle pulse. A req[i] still high in the following IDLE cycle
// is treated as a new request.
module bus_arbiter #(
   parameter int NREQ    = 3,
   parameter int MEM_LAT = 2,
   parameter int MEM_TOP = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*9-1:0] reqMsg,
   input  logic [8:0]        memOut,
   output logic [NREQ-1:0]   gnt,
   output logic [8:0]        bus,
   output logic [3:0]        rdData,
   output logic              rdValid,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic              busy,
`ifdef BUS_STATS_EN
   output logic [7:0]        rdCnt,
   output logic [7:0]        wbCnt,
   output logic [7:0]        invCnt,
   output logic [7:0]        errCnt,
`endif
   output logic [1:0]        dbg_state_o
);

   localparam int          IDXW     = $clog2(NREQ);
   localparam int          LATW     = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
   localparam logic [8:0]  IDLE_MSG = 9'h180;
   localparam logic [1:0]  OP_RD    = 2'd0;
   localparam logic [1:0]  OP_WB    = 2'd1;
   localparam logic [1:0]  OP_INV   = 2'd2;
   localparam logic [1:0]  OP_NOP   = 2'd3;
   localparam logic [2:0]  TAG_TOP  = 3'(MEM_TOP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q;
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] cur_q;
   logic [1:0]      op_q;
   logic [LATW-1:0] lat_q;

   logic [IDXW-1:0] sel_d;
   logic            found_d;
   logic [8:0]      sel_msg_d;

`ifdef BUS_STATS_EN
   logic [7:0] rd_cnt_q;
   logic [7:0] wb_cnt_q;
   logic [7:0] inv_cnt_q;
   logic [7:0] err_cnt_q;

   assign rdCnt  = rd_cnt_q;
   assign wbCnt  = wb_cnt_q;
   assign invCnt = inv_cnt_q;
   assign errCnt = err_cnt_q;
`endif

   // Only the data nibble of the memory return is meaningful.
   logic unused_mem_bits;
   assign unused_mem_bits = &{1'b0, memOut[8:4]};

   assign dbg_state_o = state_q;

   function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
      return {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Round-robin pick: first asserted request scanning upward from ptr, wrapping.
   always_comb begin
      int j;
      found_d = 1'b0;
      sel_d   = '0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found_d && req[j]) begin
            found_d = 1'b1;
            sel_d   = IDXW'(j);
         end
      end
      sel_msg_d = reqMsg[9*int'(sel_d) +: 9];
   end

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         cur_q     <= '0;
         op_q      <= OP_NOP;
         lat_q     <= '0;
         bus       <= IDLE_MSG;
         gnt       <= '0;
         done      <= '0;
         rdValid   <= 1'b0;
         rdData    <= 4'h0;
         err       <= 1'b0;
         busy      <= 1'b0;
`ifdef BUS_STATS_EN
         rd_cnt_q  <= 8'h00;
         wb_cnt_q  <= 8'h00;
         inv_cnt_q <= 8'h00;
         err_cnt_q <= 8'h00;
`endif
      end else begin
         done    <= '0;
         rdValid <= 1'b0;
         err     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  cur_q <= sel_d;
                  op_q  <= sel_msg_d[8:7];
                  busy  <= 1'b1;
                  if (sel_msg_d[8:7] == OP_NOP) begin
                     // No-op message: acknowledge without a bus cycle.
                     state_q <= S_RESP;
                     done    <= onehot(sel_d);
                  end else if (sel_msg_d[6:4] > TAG_TOP) begin
                     // Tag outside memory: reject, bus stays idle.
                     state_q <= S_RESP;
                     done    <= onehot(sel_d);
                     err     <= 1'b1;
`ifdef BUS_STATS_EN
                     err_cnt_q <= sat_inc(err_cnt_q);
`endif
                  end else begin
                     state_q <= S_DRIVE;
                     gnt     <= onehot(sel_d);
                     bus     <= sel_msg_d;
                  end
               end
            end
            S_DRIVE: begin
               if (op_q == OP_RD && MEM_LAT > 1) begin
                  state_q <= S_WAIT;
                  lat_q   <= LATW'(MEM_LAT - 2);
               end else begin
                  state_q <= S_RESP;
                  gnt     <= '0;
                  bus     <= IDLE_MSG;
                  done    <= onehot(cur_q);
                  if (op_q == OP_RD) begin
                     rdData  <= memOut[3:0];
                     rdValid <= 1'b1;
                  end
`ifdef BUS_STATS_EN
                  if (op_q == OP_RD)  rd_cnt_q  <= sat_inc(rd_cnt_q);
                  if (op_q == OP_WB)  wb_cnt_q  <= sat_inc(wb_cnt_q);
                  if (op_q == OP_INV) inv_cnt_q <= sat_inc(inv_cnt_q);
`endif
               end
            end
            S_WAIT: begin
               // Read miss keeps the bus for MEM_LAT cycles in total.
               if (lat_q == '0) begin
                  state_q <= S_RESP;
                  gnt     <= '0;
                  bus     <= IDLE_MSG;
                  done    <= onehot(cur_q);
                  rdData  <= memOut[3:0];
                  rdValid <= 1'b1;
`ifdef BUS_STATS_EN
                  rd_cnt_q <= sat_inc(rd_cnt_q);
`endif
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            S_RESP: begin
               // One idle cycle so memory always sees a bus change between messages.
               state_q <= S_IDLE;
               busy    <= 1'b0;
               ptr_q   <= (cur_q == IDXW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               gnt     <= '0;
               bus     <= IDLE_MSG;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with a small memory model and a
// scoreboard of expected bus cycles and expected completions.
module tb_bus_arbiter;

  localparam int NREQ = 3;
  localparam int MEM_LAT = 2;
  localparam int MEM_TOP = 6;
  localparam logic [8:0] IDLE_MSG = 9'h180;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*9-1:0] reqMsg = '0;
  logic [8:0] memOut;
  logic [NREQ-1:0] gnt;
  logic [8:0] bus;
  logic [3:0] rdData;
  logic rdValid;
  logic [NREQ-1:0] done;
  logic err;
  logic busy;
  logic [1:0] dbg_state;
`ifdef BUS_STATS_EN
  logic [7:0] rdCnt, wbCnt, invCnt, errCnt;
`endif

  // expected bus cycles: {gnt, bus}; expected completions: {done, err, rdValid, rdData}
  logic [NREQ+8:0] bus_q[$];
  logic [NREQ+5:0] exp_q[$];

  logic [3:0] mem [0:7];
  logic [3:0] ref_mem [0:7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bus_arbiter #(.NREQ(NREQ), .MEM_LAT(MEM_LAT), .MEM_TOP(MEM_TOP)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .reqMsg(reqMsg),
    .memOut(memOut),
    .gnt(gnt),
    .bus(bus),
    .rdData(rdData),
    .rdValid(rdValid),
    .done(done),
    .err(err),
    .busy(busy),
`ifdef BUS_STATS_EN
    .rdCnt(rdCnt),
    .wbCnt(wbCnt),
    .invCnt(invCnt),
    .errCnt(errCnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] init_val(input int t);
    return 4'(t * 3 + 1);
  endfunction

  // memory model: returns contents of the tag on the bus, writes on writeBack
  assign memOut = {2'b00, bus[6:4], mem[bus[6:4]]};
  always @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < 8; t++) mem[t] <= init_val(t);
    end else if (bus[8:7] == 2'b01) begin
      mem[bus[6:4]] <= bus[3:0];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    logic [NREQ+8:0] be;
    logic [NREQ+5:0] re;
    if (!reset) begin
      if (bus !== IDLE_MSG) begin
        checks++;
        assert (bus_q.size() != 0) else begin
          errors++;
          $error("FAIL bus_unexpected observed=%h expected=%h", bus, IDLE_MSG);
        end
        if (bus_q.size() != 0) begin
          be = bus_q.pop_front();
          checks++;
          assert ({gnt, bus} === be) else begin
            errors++;
            $error("FAIL bus_cycle observed gnt=%b bus=%h expected gnt=%b bus=%h",
                   gnt, bus, be[NREQ+8:9], be[8:0]);
          end
        end
      end else begin
        checks++;
        assert (gnt === '0) else begin
          errors++;
          $error("FAIL gnt_idle observed=%b expected=0", gnt);
        end
      end
      if (done !== '0 || err !== 1'b0 || rdValid !== 1'b0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL resp_unexpected observed done=%b err=%b rdValid=%b expected none",
                 done, err, rdValid);
        end
        if (exp_q.size() != 0) begin
          re = exp_q.pop_front();
          checks++;
          assert ({done, err, rdValid} === re[NREQ+5:4]) else begin
            errors++;
            $error("FAIL resp observed done=%b err=%b rdValid=%b expected done=%b err=%b rdValid=%b",
                   done, err, rdValid, re[NREQ+5:6], re[5], re[4]);
          end
          if (re[4]) begin
            checks++;
            assert (rdData === re[3:0]) else begin
              errors++;
              $error("FAIL rd_data observed=%h expected=%h", rdData, re[3:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic init_ref();
    for (int t = 0; t < 8; t++) ref_mem[t] = init_val(t);
  endtask

  task automatic push_exp(input int idx, input logic [8:0] msg);
    logic [NREQ-1:0] oh;
    logic [1:0] op;
    logic [2:0] tag;
    oh = NREQ'(1) << idx;
    op = msg[8:7];
    tag = msg[6:4];
    if (op == 2'd3) begin
      exp_q.push_back({oh, 1'b0, 1'b0, 4'h0});
    end else if (int'(tag) > MEM_TOP) begin
      exp_q.push_back({oh, 1'b1, 1'b0, 4'h0});
    end else if (op == 2'd0) begin
      for (int n = 0; n < MEM_LAT; n++) bus_q.push_back({oh, msg});
      exp_q.push_back({oh, 1'b0, 1'b1, ref_mem[tag]});
    end else begin
      bus_q.push_back({oh, msg});
      if (op == 2'd1) ref_mem[tag] = msg[3:0];
      exp_q.push_back({oh, 1'b0, 1'b0, 4'h0});
    end
  endtask

  // one complete transaction from a single requester; returns req-to-done latency
  task automatic run_txn(input int idx, input logic [8:0] msg, output int lat);
    int t0;
    bit seen;
    push_exp(idx, msg);
    reqMsg[9*idx +: 9] = msg;
    req[idx] = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    lat = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clock); #1;
      if (done[idx]) begin
        seen = 1'b1;
        lat = cyc - t0;
      end
    end
    req[idx] = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    init_ref();
    bus_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int cnt;
    int tdone[4];
    bit seen;

    init_ref();
    do_reset();

    // reset state
    chk("rst_bus", 32'(bus), 32'(IDLE_MSG));
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdvalid", 32'(rdValid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rddata", 32'(rdData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // reset in the middle of a read miss aborts it silently
    reqMsg[9*1 +: 9] = 9'h040;
    req[1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clock); #1;
      if (gnt !== '0) seen = 1'b1;
    end
    chk("abort_gnt", 32'(gnt), 32'b010);
    reset = 1'b1;
    #1;
    chk("abort_bus", 32'(bus), 32'(IDLE_MSG));
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rdvalid", 32'(rdValid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    req = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    init_ref();
    repeat (4) @(posedge clock);
    #1;

    // all three read misses held: grants rotate from requester 0
    for (int i = 0; i < NREQ; i++) reqMsg[9*i +: 9] = {2'b00, 3'(i + 1), 4'h0};
    push_exp(0, reqMsg[8:0]);
    push_exp(1, reqMsg[17:9]);
    push_exp(2, reqMsg[26:18]);
    push_exp(0, reqMsg[8:0]);
    req = 3'b111;
    cnt = 0;
    for (int n = 0; n < 80 && cnt < 4; n++) begin
      @(posedge clock); #1;
      if (done !== '0) begin
        tdone[cnt] = cyc;
        cnt++;
      end
    end
    req = '0;
    chk("rr_count", 32'(cnt), 32'd4);
    for (int k = 0; k < 3; k++) chk("rr_period", 32'(tdone[k+1] - tdone[k]), 32'(MEM_LAT + 2));
    @(posedge clock); #1;

    // writeBack then readMiss of the same tag
    run_txn(0, 9'h0A5, lat);
    chk("wb_latency", 32'(lat), 32'd2);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'd0);
    run_txn(0, 9'h020, lat);
    chk("rd_latency", 32'(lat), 32'(MEM_LAT + 1));

    // out-of-range tag is rejected without a bus cycle
    run_txn(1, {2'b00, 3'd7, 4'h9}, lat);
    run_txn(2, {2'b01, 3'd7, 4'h3}, lat);
    chk("err_latency", 32'(lat), 32'd1);

    // invalidate is snooper-only: memory contents stay as they were
    run_txn(0, 9'h130, lat);
    run_txn(2, 9'h030, lat);

    // highest valid tag is accepted
    run_txn(2, {2'b01, 3'(MEM_TOP), 4'hC}, lat);
    run_txn(1, {2'b00, 3'(MEM_TOP), 4'h0}, lat);

    // no-op message completes with no bus cycle
    run_txn(1, 9'h1A7, lat);
    run_txn(1, 9'h020, lat);

    // random writeBacks then readbacks through different requesters
    for (int i = 0; i < 6; i++) begin
      run_txn(int'($urandom_range(0, NREQ - 1)),
              {2'b01, 3'($urandom_range(0, MEM_TOP)), 4'($urandom_range(0, 15))}, lat);
      run_txn(int'($urandom_range(0, NREQ - 1)),
              {2'b00, 3'($urandom_range(0, MEM_TOP)), 4'h0}, lat);
    end

`ifdef BUS_STATS_EN
    do_reset();
    for (int i = 0; i < 300; i++) run_txn(i % NREQ, {2'b01, 3'(i % 7), 4'(i)}, lat);
    run_txn(0, 9'h130, lat);
    run_txn(1, {2'b10, 3'd7, 4'h0}, lat);
    chk("stat_wb", 32'(wbCnt), 32'd255);
    chk("stat_rd", 32'(rdCnt), 32'd0);
    chk("stat_inv", 32'(invCnt), 32'd1);
    chk("stat_err", 32'(errCnt), 32'd1);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
